// File: rtl/aes_encrypt_iterative.sv
// Purpose : iterative AES-128 encryption, one round per clock, round keys expanded on the fly.
// Latency : 10 cycles from the accept edge to out_valid; one block every 12 cycles at best.
// Backpr. : the result is held in DONE until out_ready; no new block is taken until the engine is idle again.
// Ports   : clk, rst_n (async, active low)
//           in_valid/in_ready, plaintext, key  -- block + cipher key in, byte 0 = bits [0:7]
//           out_valid/out_ready, ciphertext, last_key -- result + round-10 key out
//           busy -- high while rounds are being computed
module aes_encrypt_iterative (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] plaintext,
   input  logic [0:127] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] ciphertext,
   output logic [0:127] last_key,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [0:127] state_reg, rkey_reg;
   logic [3:0]   round_cnt;
   logic [7:0]   rcon_reg;
   logic [0:127] sr, mc, next_key, round_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box computed algebraically: multiplicative inverse (a^254, which maps 0 to 0)
   // followed by the affine transform, instead of a 256-entry table.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq, inv, b;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      b = inv;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Column-major state: row r, column c lives in byte r + 4c. Row r rotates left by r.
   function automatic logic [0:127] shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         o[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Word j is bytes 4j..4j+3 with byte 4j in the MSBs of the 32-bit word.
   function automatic logic [0:127] key_expand(input logic [0:127] k, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3, rot, t;
      w0  = k[0  +: 32];
      w1  = k[32 +: 32];
      w2  = k[64 +: 32];
      w3  = k[96 +: 32];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
      w0  = w0 ^ t;
      w1  = w1 ^ w0;
      w2  = w2 ^ w1;
      w3  = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   assign next_key  = key_expand(rkey_reg, rcon_reg);
   assign sr        = shift_rows(sub_bytes(state_reg));
   assign mc        = mix_columns(sr);
   // The final round has no MixColumns.
   assign round_out = ((round_cnt == 4'd10) ? sr : mc) ^ next_key;

   assign in_ready  = (fsm == IDLE);
   assign busy      = (fsm == ROUND);
   assign out_valid = (fsm == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm <= IDLE;
      else        fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE:    if (in_valid)              fsm_nxt = ROUND;
         ROUND:   if (round_cnt == 4'd10)    fsm_nxt = DONE;
         DONE:    if (out_ready)             fsm_nxt = IDLE;
         default:                            fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= '0;
         rkey_reg   <= '0;
         ciphertext <= '0;
         last_key   <= '0;
         round_cnt  <= 4'd0;
         rcon_reg   <= 8'h01;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= plaintext ^ key;
                  rkey_reg  <= key;
                  rcon_reg  <= 8'h01;
                  round_cnt <= 4'd1;
               end
            end
            ROUND: begin
               state_reg <= round_out;
               rkey_reg  <= next_key;
               round_cnt <= round_cnt + 4'd1;
               rcon_reg  <= xtime(rcon_reg);
               if (round_cnt == 4'd10) begin
                  ciphertext <= round_out;
                  last_key   <= next_key;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
module tb_aes_encrypt_iterative;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [0:127] plaintext = '0;
   logic [0:127] key = '0;
   logic         in_ready, out_valid, busy;
   logic [0:127] ciphertext, last_key;

   localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] LK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cyc = -1;
   int ret_cyc = -1;
   int acc_cnt = 0;

   logic [0:127] exp_ct_q[$];
   logic [0:127] exp_lk_q[$];

   aes_encrypt_iterative dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .last_key   (last_key),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Edge bookkeeping: edge number of the latest accept and the latest retire.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
         acc_cyc <= cyc + 1;
         acc_cnt <= acc_cnt + 1;
      end
      if (out_valid && out_ready) ret_cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [0:127] pt, input logic [0:127] k,
                       input logic [0:127] ct, input logic [0:127] lk);
      bit ok = 1'b0;
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            exp_ct_q.push_back(ct);
            exp_lk_q.push_back(lk);
            wait_cycle();
            break;
         end
         wait_cycle();
      end
      in_valid = 1'b0;
      chk("accept_timeout", 128'(ok), 128'd1);
   endtask

   task automatic get_result(output int seen);
      bit found = 1'b0;
      logic [0:127] e_ct, e_lk;
      seen = -1;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) begin
            found = 1'b1;
            seen  = cyc;
            break;
         end
         wait_cycle();
      end
      chk("result_timeout", 128'(found), 128'd1);
      if (found) begin
         chk("sb_nonempty", 128'(exp_ct_q.size() != 0), 128'd1);
         if (exp_ct_q.size() != 0) begin
            e_ct = exp_ct_q.pop_front();
            e_lk = exp_lk_q.pop_front();
            chk("ciphertext", ciphertext, e_ct);
            chk("last_key", last_key, e_lk);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen, seen_a, seen_b, ret_a, n0, ov_seen;

      // Reset state
      #12;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_ct", ciphertext, 128'd0);
      chk("rst_lk", last_key, 128'd0);
      wait_cycle();
      wait_cycle();
      rst_n = 1'b1;
      wait_cycle();

      // App. B vector, latency, retire
      out_ready = 1'b1;
      send(PT_B, KEY_B, CT_B, LK_B);
      chk("busy_round1", 128'(busy), 128'd1);
      chk("in_ready_round1", 128'(in_ready), 128'd0);
      get_result(seen);
      chk("latency_b", 128'(seen - acc_cyc), 128'd10);
      wait_cycle();
      chk("retire_out_valid", 128'(out_valid), 128'd0);
      chk("retire_in_ready", 128'(in_ready), 128'd1);

      // App. C.1 vector with backpressure
      out_ready = 1'b0;
      send(PT_C, KEY_C, CT_C, LK_C);
      get_result(seen);
      for (int i = 0; i < 20; i++) begin
         wait_cycle();
         chk("bp_out_valid", 128'(out_valid), 128'd1);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         chk("bp_ct", ciphertext, CT_C);
         chk("bp_lk", last_key, LK_C);
      end
      out_ready = 1'b1;
      wait_cycle();
      out_ready = 1'b0;
      chk("bp_release_in_ready", 128'(in_ready), 128'd1);
      chk("bp_release_out_valid", 128'(out_valid), 128'd0);
      chk("idle_ct_kept", ciphertext, CT_C);

      // In-flight inputs are rejected
      out_ready = 1'b1;
      send(PT_B, KEY_B, CT_B, LK_B);
      n0 = acc_cnt;
      wait_cycle();
      wait_cycle();
      plaintext = PT_C;
      key       = KEY_C;
      for (int i = 0; i < 4; i++) begin
         in_valid = ~in_valid;
         chk("busy_in_ready", 128'(in_ready), 128'd0);
         wait_cycle();
      end
      in_valid = 1'b0;
      get_result(seen);
      ov_seen = 0;
      for (int i = 0; i < 15; i++) begin
         wait_cycle();
         if (out_valid) ov_seen++;
      end
      chk("busy_no_second_accept", 128'(acc_cnt - n0), 128'd0);
      chk("busy_no_second_result", 128'(ov_seen), 128'd0);

      // Back-to-back: B held while A completes
      out_ready = 1'b1;
      send(PT_C, KEY_C, CT_C, LK_C);
      plaintext = PT_B;
      key       = KEY_B;
      in_valid  = 1'b1;
      exp_ct_q.push_back(CT_B);
      exp_lk_q.push_back(LK_B);
      get_result(seen_a);
      wait_cycle();
      ret_a = ret_cyc;
      for (int i = 0; i < 20; i++) begin
         if (acc_cyc > ret_a) break;
         wait_cycle();
      end
      in_valid = 1'b0;
      chk("b2b_accept_edge", 128'(acc_cyc), 128'(ret_a + 1));
      get_result(seen_b);
      chk("b2b_latency", 128'(seen_b - acc_cyc), 128'd10);
      chk("b2b_spacing", 128'(seen_b - ret_a), 128'd11);
      wait_cycle();

      // Reset in round 5
      send(PT_C, KEY_C, CT_C, LK_C);
      for (int i = 0; i < 4; i++) wait_cycle();
      chk("pre_reset_busy", 128'(busy), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
      chk("mid_rst_ct", ciphertext, 128'd0);
      chk("mid_rst_lk", last_key, 128'd0);
      if (exp_ct_q.size() != 0) begin
         void'(exp_ct_q.pop_back());
         void'(exp_lk_q.pop_back());
      end
      wait_cycle();
      wait_cycle();
      rst_n = 1'b1;
      ov_seen = 0;
      for (int i = 0; i < 15; i++) begin
         wait_cycle();
         if (out_valid) ov_seen++;
      end
      chk("post_rst_no_out_valid", 128'(ov_seen), 128'd0);
      send(PT_B, KEY_B, CT_B, LK_B);
      get_result(seen);
      chk("post_rst_latency", 128'(seen - acc_cyc), 128'd10);
      wait_cycle();
      chk("sb_drained", 128'(exp_ct_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
